// File: rtl/tx_hs_pkg.sv
// Shared definitions for the D-PHY HS transmit path: FSM state encodings,
// sync/trail bytes and the burst controller state type.
package tx_hs_pkg;

  typedef enum logic [2:0] {
    HS_STOP  = 3'b000,
    HS_ZERO  = 3'b001,
    HS_SYNC  = 3'b010,
    HS_DATA  = 3'b011,
    HS_TRAIL = 3'b100
  } hs_state_e;

  localparam logic [7:0] HS_SYNC_BYTE  = 8'h1D;
  localparam logic [7:0] HS_TRAIL_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    C_IDLE,
    C_SEND,
    C_WAIT_TRAIL
  } ctrl_state_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous FIFO with combinational head read; DEPTH must be a power of two.
module tx_byte_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_hs_burst_ctrl.sv
// HS burst controller: buffers application bytes and sequences Enable/byte
// handoff to the HS transmitter FSM, with a minimum LP gap between bursts.
module tx_hs_burst_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned START_THRESH = 8,
  parameter int unsigned T_LP_GAP     = 6
) (
  input  logic                              TX_DDR_clk,
  input  logic                              TX_rst,
  input  logic                              wr_valid,
  input  logic [7:0]                        wr_data,
  input  logic                              wr_last,
  output logic                              wr_ready,
  input  logic [2:0]                        TX_HS_STATE,
  output logic                              Enable,
  output logic                              TX_VALID,
  output logic [7:0]                        TX_BYTE_DATA,
  output logic                              TX_HS_END_DATA,
  output logic                              busy,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  import tx_hs_pkg::*;

  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GW = $clog2(T_LP_GAP + 2);

  ctrl_state_e   state;
  hs_state_e     hs;
  logic [8:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] level;
  logic [LW-1:0] pkt_cnt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_nxt;
  logic          wr_acc;
  logic          pop;
  logic          pop_last;
  logic          start_ok;

  tx_byte_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (TX_DDR_clk),
    .rst     (TX_rst),
    .wr_en   (wr_valid),
    .wr_data ({wr_last, wr_data}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign hs         = hs_state_e'(TX_HS_STATE);
  assign wr_ready   = ~fifo_full;
  assign wr_acc     = wr_valid & ~fifo_full;
  assign fifo_level = level;
  assign busy       = (state != C_IDLE);

  assign pop            = (state == C_SEND) && (hs == HS_DATA) && !fifo_empty;
  assign pop_last       = pop & head[8];
  assign TX_VALID       = pop;
  assign TX_BYTE_DATA   = pop ? head[7:0] : '0;
  assign TX_HS_END_DATA = pop_last;

  // Gap test uses the post-increment value so the launch decision lands in the
  // T_LP_GAP-th IDLE cycle, giving a T_LP_GAP+1 Enable-low window from STOP.
  assign gap_nxt  = (gap_cnt == GW'(T_LP_GAP)) ? gap_cnt : gap_cnt + GW'(1);
  assign start_ok = (gap_nxt == GW'(T_LP_GAP)) &&
                    ((pkt_cnt != '0) || (level >= LW'(START_THRESH)));

  always_comb begin
    Enable = 1'b0;
    case (state)
      C_SEND:       Enable = 1'b1;
      C_WAIT_TRAIL: Enable = (hs != HS_STOP);
      default:      Enable = 1'b0;
    endcase
  end

  always_ff @(posedge TX_DDR_clk) begin
    if (TX_rst) begin
      state    <= C_IDLE;
      pkt_cnt  <= '0;
      gap_cnt  <= GW'(T_LP_GAP);
      underrun <= 1'b0;
    end else begin
      case ({wr_acc & wr_last, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + LW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - LW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase

      case (state)
        C_IDLE: begin
          gap_cnt <= gap_nxt;
          if (start_ok) begin
            state <= C_SEND;
          end
        end
        C_SEND: begin
          if ((hs == HS_DATA) && fifo_empty) begin
            underrun <= 1'b1;
          end
          if (pop_last) begin
            state <= C_WAIT_TRAIL;
          end
        end
        C_WAIT_TRAIL: begin
          if (hs == HS_STOP) begin
            state   <= C_IDLE;
            gap_cnt <= '0;
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_hs_burst_ctrl.sv
// Bench for tx_hs_burst_ctrl: a reactive HS FSM model drives TX_HS_STATE and a
// byte scoreboard checks every popped byte, FIFO level and underrun each cycle.
module tb_tx_hs_burst_ctrl;
  import tx_hs_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 8;
  localparam int unsigned GAP    = 6;

  logic       TX_DDR_clk;
  logic       TX_rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_ready;
  logic [2:0] TX_HS_STATE;
  logic       Enable;
  logic       TX_VALID;
  logic [7:0] TX_BYTE_DATA;
  logic       TX_HS_END_DATA;
  logic       busy;
  logic       underrun;
  logic [4:0] fifo_level;

  tx_hs_burst_ctrl #(
    .FIFO_DEPTH   (DEPTH),
    .START_THRESH (THRESH),
    .T_LP_GAP     (GAP)
  ) dut (
    .TX_DDR_clk     (TX_DDR_clk),
    .TX_rst         (TX_rst),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .wr_ready       (wr_ready),
    .TX_HS_STATE    (TX_HS_STATE),
    .Enable         (Enable),
    .TX_VALID       (TX_VALID),
    .TX_BYTE_DATA   (TX_BYTE_DATA),
    .TX_HS_END_DATA (TX_HS_END_DATA),
    .busy           (busy),
    .underrun       (underrun),
    .fifo_level     (fifo_level)
  );

  initial TX_DDR_clk = 1'b0;
  always #5 TX_DDR_clk = ~TX_DDR_clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [8:0] sb[$];
  logic [2:0] fsm_nxt;
  int         fsm_cnt = 0;
  int         hold_cnt = 0;
  logic       exp_under = 1'b0;

  logic       s_en, s_valid, s_end, s_busy, s_ready, s_under;
  logic [7:0] s_data;
  logic [4:0] s_level;
  logic       prev_en = 1'b0;
  logic [2:0] prev_fsm = 3'b000;
  logic       stop_seen = 1'b0, stop_en = 1'b0, rise_seen = 1'b0;
  int         stop_cyc = 0, rise_cyc = 0;
  int         valid_run = 0, max_run = 0, end_cnt = 0;
  logic [7:0] last_end_byte = 8'h00;
  int         sync_cycles = 0, sync_valid = 0;

  // Samples and checks one cycle, then advances the HS FSM model.
  task automatic monitor();
    logic       exp_valid;
    logic       acc;
    logic [8:0] exp;
    int         sz;
    s_en = Enable; s_valid = TX_VALID; s_end = TX_HS_END_DATA; s_data = TX_BYTE_DATA;
    s_busy = busy; s_ready = wr_ready; s_under = underrun; s_level = fifo_level;
    cyc++;
    if (TX_rst) begin
      sb.delete();
      exp_under = 1'b0;
    end else begin
      sz = sb.size();
      tests++;
      if (s_level !== 5'(sz)) begin
        fails++; $display("FAIL fifo_level cyc=%0d got=%0d exp=%0d", cyc, s_level, sz);
      end
      tests++;
      if (s_ready !== (sz < DEPTH)) begin
        fails++; $display("FAIL wr_ready cyc=%0d got=%b exp=%b", cyc, s_ready, (sz < DEPTH));
      end
      tests++;
      if (s_under !== exp_under) begin
        fails++; $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, s_under, exp_under);
      end
      if ((s_en === 1'b1) && (TX_HS_STATE == HS_DATA) && (sz == 0)) exp_under = 1'b1;
      acc = (wr_valid === 1'b1) && (sz < DEPTH);
      exp_valid = (s_en === 1'b1) && (TX_HS_STATE == HS_DATA) && (sz > 0);
      tests++;
      if (s_valid !== exp_valid) begin
        fails++; $display("FAIL tx_valid cyc=%0d got=%b exp=%b", cyc, s_valid, exp_valid);
      end
      if ((s_valid === 1'b1) && exp_valid) begin
        exp = sb.pop_front();
        tests++;
        if ({s_end, s_data} !== exp) begin
          fails++; $display("FAIL pop_byte cyc=%0d got=%h exp=%h", cyc, {s_end, s_data}, exp);
        end
      end else if (s_valid !== 1'b1) begin
        tests++;
        if ((s_data !== 8'h00) || (s_end !== 1'b0)) begin
          fails++; $display("FAIL idle_bus cyc=%0d got data=%h end=%b exp 00/0", cyc, s_data, s_end);
        end
      end
      if (acc) sb.push_back({wr_last, wr_data});
      if (TX_HS_STATE == HS_SYNC) begin
        sync_cycles++;
        if (s_valid === 1'b1) sync_valid++;
      end
    end
    valid_run = (s_valid === 1'b1) ? valid_run + 1 : 0;
    if (valid_run > max_run) max_run = valid_run;
    if ((s_valid === 1'b1) && (s_end === 1'b1)) begin
      end_cnt++;
      last_end_byte = s_data;
    end
    if ((TX_HS_STATE == HS_STOP) && (prev_fsm == HS_TRAIL)) begin
      stop_seen = 1'b1; stop_cyc = cyc; stop_en = s_en;
    end
    if ((s_en === 1'b1) && (prev_en !== 1'b1)) begin
      rise_seen = 1'b1; rise_cyc = cyc;
    end
    fsm_nxt = TX_HS_STATE;
    case (TX_HS_STATE)
      HS_STOP:
        if (s_en === 1'b1) begin fsm_nxt = HS_ZERO; fsm_cnt = 0; end
      HS_ZERO:
        if (s_en !== 1'b1) fsm_nxt = HS_STOP;
        else if (fsm_cnt == 3) begin fsm_nxt = HS_SYNC; fsm_cnt = 0; end
        else fsm_cnt++;
      HS_SYNC:
        if (s_en !== 1'b1) fsm_nxt = HS_STOP;
        else if (hold_cnt > 0) hold_cnt--;
        else if (fsm_cnt == 3) begin fsm_nxt = HS_DATA; fsm_cnt = 0; end
        else fsm_cnt++;
      HS_DATA:
        if (s_en !== 1'b1) fsm_nxt = HS_STOP;
        else if ((s_valid === 1'b1) && (s_end === 1'b1)) begin fsm_nxt = HS_TRAIL; fsm_cnt = 0; end
      HS_TRAIL:
        if (fsm_cnt == 2) fsm_nxt = HS_STOP;
        else fsm_cnt++;
      default: fsm_nxt = HS_STOP;
    endcase
    prev_en = s_en;
    prev_fsm = TX_HS_STATE;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic l);
    wr_valid = v; wr_data = d; wr_last = l;
    @(negedge TX_DDR_clk);
    monitor();
    @(posedge TX_DDR_clk);
    #1;
    TX_HS_STATE = fsm_nxt;
    wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
  endtask

  task automatic wait_stop(input string name, input int budget);
    for (int i = 0; i < budget && !stop_seen; i++) cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (!stop_seen) begin
      fails++; $display("FAIL %s_stop_timeout got=no STOP exp=STOP within %0d", name, budget);
    end
  endtask

  task automatic wait_data(input string name, input int budget);
    for (int i = 0; i < budget && TX_HS_STATE != HS_DATA; i++) cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (TX_HS_STATE != HS_DATA) begin
      fails++; $display("FAIL %s_data_timeout got=%0d exp=DATA", name, TX_HS_STATE);
    end
  endtask

  task automatic check_post_reset(input string name);
    tests++;
    if ({s_en, s_valid, s_level, s_busy, s_ready, s_under} !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL %s got en=%b valid=%b level=%0d busy=%b ready=%b under=%b exp 0/0/0/0/1/0",
               name, s_en, s_valid, s_level, s_busy, s_ready, s_under);
    end
  endtask

  task automatic test_reset();
    TX_rst = 1'b1;
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    TX_rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    check_post_reset("reset_state");
  endtask

  task automatic test_basic();
    int w;
    stop_seen = 0; rise_seen = 0; max_run = 0; end_cnt = 0;
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b1);
    w = cyc;
    wait_stop("basic", 60);
    tests++;
    if (!rise_seen || rise_cyc != w + 2) begin
      fails++; $display("FAIL basic_enable_rise got=%0d exp=%0d", rise_cyc - w, 2);
    end
    tests++;
    if (max_run != 3) begin fails++; $display("FAIL basic_run got=%0d exp=3", max_run); end
    tests++;
    if (end_cnt != 1 || last_end_byte !== 8'h33) begin
      fails++; $display("FAIL basic_end got=%0d/%h exp=1/33", end_cnt, last_end_byte);
    end
    tests++;
    if (stop_en !== 1'b0) begin fails++; $display("FAIL basic_stop_enable got=%b exp=0", stop_en); end
    tests++;
    if (s_under !== 1'b0) begin fails++; $display("FAIL basic_underrun got=%b exp=0", s_under); end
  endtask

  task automatic test_underrun();
    stop_seen = 0; max_run = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 60 && !(TX_HS_STATE == HS_DATA && sb.size() == 0); i++) cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (max_run != 8) begin fails++; $display("FAIL thresh_run got=%0d exp=8", max_run); end
    cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (s_valid !== 1'b0) begin fails++; $display("FAIL underrun_valid got=%b exp=0", s_valid); end
    cycle(1'b1, 8'h5A, 1'b1);
    tests++;
    if (s_under !== 1'b1) begin fails++; $display("FAIL underrun_flag got=%b exp=1", s_under); end
    cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if ({s_valid, s_end, s_data} !== {1'b1, 1'b1, 8'h5A}) begin
      fails++; $display("FAIL underrun_resume got=%b/%b/%h exp=1/1/5a", s_valid, s_end, s_data);
    end
    wait_stop("underrun", 40);
  endtask

  task automatic test_back_to_back();
    int s0;
    stop_seen = 0;
    cycle(1'b1, 8'hA1, 1'b0);
    cycle(1'b1, 8'hA2, 1'b1);
    cycle(1'b1, 8'hB1, 1'b0);
    cycle(1'b1, 8'hB2, 1'b1);
    wait_stop("b2b_first", 60);
    s0 = stop_cyc;
    tests++;
    if (stop_en !== 1'b0) begin fails++; $display("FAIL b2b_stop_enable got=%b exp=0", stop_en); end
    rise_seen = 0;
    for (int i = 0; i < 30 && !rise_seen; i++) cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (!rise_seen || (rise_cyc - s0) != GAP + 1) begin
      fails++; $display("FAIL b2b_gap got=%0d exp=%0d", rise_cyc - s0, GAP + 1);
    end
    stop_seen = 0;
    wait_stop("b2b_second", 60);
  endtask

  task automatic test_fill();
    hold_cnt = 1000;
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (s_level !== 5'd16 || s_ready !== 1'b0) begin
      fails++; $display("FAIL fill_full got level=%0d ready=%b exp=16/0", s_level, s_ready);
    end
    hold_cnt = 0;
    wait_data("fill", 20);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (s_level !== 5'd15) begin fails++; $display("FAIL fill_simul_level got=%0d exp=15", s_level); end
    stop_seen = 0;
    wait_stop("fill", 60);
    rise_seen = 0;
    repeat (20) cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (rise_seen) begin fails++; $display("FAIL fill_pkt_cnt got=extra burst exp=idle"); end
  endtask

  task automatic test_sync_hold();
    hold_cnt = 10; sync_cycles = 0; sync_valid = 0;
    cycle(1'b1, 8'hC1, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0);
    cycle(1'b1, 8'hC3, 1'b1);
    wait_data("sync", 80);
    tests++;
    if (sync_valid != 0 || sync_cycles != 14) begin
      fails++; $display("FAIL sync_hold got valid=%0d cycles=%0d exp=0/14", sync_valid, sync_cycles);
    end
    cycle(1'b0, 8'h00, 1'b0);
    tests++;
    if (s_valid !== 1'b1 || s_data !== 8'hC1) begin
      fails++; $display("FAIL sync_first_pop got=%b/%h exp=1/c1", s_valid, s_data);
    end
    stop_seen = 0;
    wait_stop("sync", 40);
  endtask

  task automatic test_midburst_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'hD0 + 8'(i), (i == 5));
    wait_data("midrst", 40);
    cycle(1'b0, 8'h00, 1'b0);
    TX_rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    TX_rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    check_post_reset("midburst_reset");
    repeat (10) cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    TX_rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
    TX_HS_STATE = HS_STOP; fsm_nxt = HS_STOP;
    @(posedge TX_DDR_clk);
    #1;
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_fill();
    test_sync_hold();
    test_midburst_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
